// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard scheduler: Tuse/Tnew constants, forward
// select encodings, the pipeline record type and small record helpers.
package hazard_defs;

  localparam int TNEW_W = 2;
  localparam int REG_W  = 5;

  localparam logic [1:0] TUSE_D    = 2'd0;
  localparam logic [1:0] TUSE_E    = 2'd1;
  localparam logic [1:0] TUSE_M    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [TNEW_W-1:0] TNEW_0 = TNEW_W'(0);
  localparam logic [TNEW_W-1:0] TNEW_1 = TNEW_W'(1);
  localparam logic [TNEW_W-1:0] TNEW_2 = TNEW_W'(2);

  localparam logic [1:0] FWD_D_GRF = 2'd0;
  localparam logic [1:0] FWD_D_E   = 2'd1;
  localparam logic [1:0] FWD_D_M   = 2'd2;
  localparam logic [1:0] FWD_D_W   = 2'd3;
  localparam logic [1:0] FWD_E_REG = 2'd0;
  localparam logic [1:0] FWD_E_M   = 2'd1;
  localparam logic [1:0] FWD_E_W   = 2'd2;
  localparam logic       FWD_M_REG = 1'b0;
  localparam logic       FWD_M_W   = 1'b1;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;

  typedef struct packed {
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  a3;
    logic [TNEW_W-1:0] tnew;
  } rec_t;

  localparam rec_t BUBBLE = '0;

  function automatic rec_t age_rec(input rec_t r);
    age_rec = r;
    if (r.tnew != TNEW_0) age_rec.tnew = r.tnew - TNEW_W'(1);
  endfunction

  function automatic logic writes_reg(input rec_t r, input logic [REG_W-1:0] idx);
    return (idx != '0) && (r.a3 == idx);
  endfunction

  function automatic logic src_ready(input rec_t r, input logic [REG_W-1:0] idx);
    return writes_reg(r, idx) && (r.tnew == TNEW_0);
  endfunction

  function automatic logic too_late(input rec_t r, input logic [REG_W-1:0] idx,
                                    input logic [1:0] tuse);
    return writes_reg(r, idx) && (r.tnew > tuse);
  endfunction

  // Nearest ready producer wins; a not-yet-ready nearer match falls through.
  function automatic logic [1:0] sel_d(input logic [REG_W-1:0] idx,
                                       input rec_t e, input rec_t m, input rec_t w);
    if (src_ready(e, idx)) return FWD_D_E;
    if (src_ready(m, idx)) return FWD_D_M;
    if (src_ready(w, idx)) return FWD_D_W;
    return FWD_D_GRF;
  endfunction

  function automatic logic [1:0] sel_e(input logic [REG_W-1:0] idx,
                                       input rec_t m, input rec_t w);
    if (src_ready(m, idx)) return FWD_E_M;
    if (src_ready(w, idx)) return FWD_E_W;
    return FWD_E_REG;
  endfunction

endpackage

// File: rtl/hazard_decode.sv
// Combinational decode of the D-stage instruction into operand indices,
// operand need-times, destination register and result latency from E.
module hazard_decode
  import hazard_defs::*;
(
  input  logic [31:0]       instr,
  output logic [REG_W-1:0]  rs,
  output logic [REG_W-1:0]  rt,
  output logic [1:0]        tuse_rs,
  output logic [1:0]        tuse_rt,
  output logic [REG_W-1:0]  a3,
  output logic [TNEW_W-1:0] tnew_e
);

  logic unused_shamt;
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    tuse_rs = TUSE_NONE;
    tuse_rt = TUSE_NONE;
    a3      = '0;
    tnew_e  = TNEW_0;
    case (instr[31:26])
      OP_SPECIAL: begin
        case (instr[5:0])
          FN_ADDU, FN_SUBU: begin
            tuse_rs = TUSE_E;
            tuse_rt = TUSE_E;
            a3      = instr[15:11];
            tnew_e  = TNEW_1;
          end
          FN_JR:   tuse_rs = TUSE_D;
          default: ;
        endcase
      end
      OP_BEQ: begin
        tuse_rs = TUSE_D;
        tuse_rt = TUSE_D;
      end
      OP_ORI: begin
        tuse_rs = TUSE_E;
        a3      = instr[20:16];
        tnew_e  = TNEW_1;
      end
      OP_LUI: begin
        a3     = instr[20:16];
        tnew_e = TNEW_1;
      end
      OP_LW: begin
        tuse_rs = TUSE_E;
        a3      = instr[20:16];
        tnew_e  = TNEW_2;
      end
      OP_SW: begin
        tuse_rs = TUSE_E;
        tuse_rt = TUSE_M;
      end
      OP_JAL: begin
        a3     = REG_W'(31);
        tnew_e = TNEW_0;
      end
      default: ;
    endcase
  end

  // Unused operand fields read as $0 so they never match a producer.
  assign rs = (tuse_rs != TUSE_NONE) ? instr[25:21] : '0;
  assign rt = (tuse_rt != TUSE_NONE) ? instr[20:16] : '0;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard scheduler for the 5-stage pipeline: tracks E/M/W producers and drives
// stall plus forwarding selects. Forwarding is built only with HAZARD_FWD_EN.
module hazard_ctrl
  import hazard_defs::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr_d,
  output logic        stall,
  output logic [1:0]  fwd_rs_d,
  output logic [1:0]  fwd_rt_d,
  output logic [1:0]  fwd_rs_e,
  output logic [1:0]  fwd_rt_e,
  output logic        fwd_rt_m
);

  logic [REG_W-1:0]  d_rs, d_rt, d_a3;
  logic [1:0]        d_tuse_rs, d_tuse_rt;
  logic [TNEW_W-1:0] d_tnew;
  rec_t              d_rec, e_q, m_q, w_q;

  hazard_decode u_decode (
    .instr   (instr_d),
    .rs      (d_rs),
    .rt      (d_rt),
    .tuse_rs (d_tuse_rs),
    .tuse_rt (d_tuse_rt),
    .a3      (d_a3),
    .tnew_e  (d_tnew)
  );

  always_comb begin
    d_rec      = BUBBLE;
    d_rec.rs   = d_rs;
    d_rec.rt   = d_rt;
    d_rec.a3   = d_a3;
    d_rec.tnew = d_tnew;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_q <= BUBBLE;
      m_q <= BUBBLE;
      w_q <= BUBBLE;
    end else begin
      w_q <= age_rec(m_q);
      m_q <= age_rec(e_q);
      e_q <= stall ? BUBBLE : d_rec;
    end
  end

`ifdef HAZARD_FWD_EN
  always_comb begin
    stall = too_late(e_q, d_rs, d_tuse_rs) || too_late(m_q, d_rs, d_tuse_rs) ||
            too_late(e_q, d_rt, d_tuse_rt) || too_late(m_q, d_rt, d_tuse_rt);
  end

  always_comb begin
    fwd_rs_d = sel_d(d_rs, e_q, m_q, w_q);
    fwd_rt_d = sel_d(d_rt, e_q, m_q, w_q);
    fwd_rs_e = sel_e(e_q.rs, m_q, w_q);
    fwd_rt_e = sel_e(e_q.rt, m_q, w_q);
    fwd_rt_m = src_ready(w_q, m_q.rt) ? FWD_M_W : FWD_M_REG;
  end
`else
  // Without forwarding the GRF has no write-through, so any pending write blocks.
  always_comb begin
    stall = writes_reg(e_q, d_rs) || writes_reg(m_q, d_rs) || writes_reg(w_q, d_rs) ||
            writes_reg(e_q, d_rt) || writes_reg(m_q, d_rt) || writes_reg(w_q, d_rt);
  end

  always_comb begin
    fwd_rs_d = FWD_D_GRF;
    fwd_rt_d = FWD_D_GRF;
    fwd_rs_e = FWD_E_REG;
    fwd_rt_e = FWD_E_REG;
    fwd_rt_m = FWD_M_REG;
  end
`endif

  logic unused_state;
  assign unused_state = ^{e_q, m_q, w_q, d_tuse_rs, d_tuse_rt};

endmodule
